// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants for the F/D pipeline register: reset/handler vectors,
// exception codes and the NOP encoding used for bubbles.
package fd_pipe_reg_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

  // A faulting fetch must never hand decode the bits that came back.
  function automatic logic [31:0] fetchedInstr(input logic [31:0] instr,
                                               input logic [4:0]  exc);
    return (exc == EXC_NONE) ? instr : INSTR_NOP;
  endfunction

endpackage

// File: rtl/fd_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset and clear;
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear)
      r_count <= '0;
    else if (i_inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register: stall hold, exception and ERET flush with the same
// priority as the PC register. Optional perf counters under FD_PERF_CNT_EN.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P   = RESET_PC,
  parameter logic [31:0] HANDLER_PC_P = HANDLER_PC,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req,
  input  logic             eret_clr,
  input  logic [31:0]      eret_epc,
  input  logic [31:0]      f_pc,
  input  logic [31:0]      f_instr,
  input  logic [4:0]       f_exc,
  input  logic             f_bd,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_instr,
  output logic [4:0]       d_exc,
  output logic             d_bd,
  output logic             d_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [4:0]  r_exc;
  logic        r_bd;
  logic        r_valid;

  // Priority reset > req > eret_clr > en; flushes ignore en so a stalled
  // register is still squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC_P;
      r_instr <= INSTR_NOP;
      r_exc   <= EXC_NONE;
      r_bd    <= 1'b0;
      r_valid <= 1'b0;
    end else if (req) begin
      r_pc    <= HANDLER_PC_P;
      r_instr <= INSTR_NOP;
      r_exc   <= EXC_NONE;
      r_bd    <= 1'b0;
      r_valid <= 1'b0;
    end else if (eret_clr) begin
      r_pc    <= eret_epc;
      r_instr <= INSTR_NOP;
      r_exc   <= EXC_NONE;
      r_bd    <= 1'b0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_pc    <= f_pc;
      r_instr <= fetchedInstr(f_instr, f_exc);
      r_exc   <= f_exc;
      r_bd    <= f_bd;
      r_valid <= 1'b1;
    end
  end

  assign d_pc    = r_pc;
  assign d_instr = r_instr;
  assign d_exc   = r_exc;
  assign d_bd    = r_bd;
  assign d_valid = r_valid;

`ifdef FD_PERF_CNT_EN
  logic w_stallInc;
  logic w_flushInc;

  assign w_stallInc = !req && !eret_clr && !en;
  assign w_flushInc = req || eret_clr;

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_inc   (w_stallInc),
    .o_count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_inc   (w_flushInc),
    .o_count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg: directed vector table, then random
// stimulus against a rule-level reference model. Honours FD_PERF_CNT_EN.
module tb_fd_pipe_reg;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, en, req, eret_clr, f_bd;
  logic [31:0]      eret_epc, f_pc, f_instr;
  logic [4:0]       f_exc;
  logic [31:0]      d_pc, d_instr;
  logic [4:0]       d_exc;
  logic             d_bd, d_valid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int nVectors    = 0;
  int nMiscompares = 0;

  fd_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .eret_clr  (eret_clr),
    .eret_epc  (eret_epc),
    .f_pc      (f_pc),
    .f_instr   (f_instr),
    .f_exc     (f_exc),
    .f_bd      (f_bd),
    .d_pc      (d_pc),
    .d_instr   (d_instr),
    .d_exc     (d_exc),
    .d_bd      (d_bd),
    .d_valid   (d_valid),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, req, eret;
    logic [31:0] epc, fpc, finstr;
    logic [4:0]  fexc;
    logic        fbd;
    logic [31:0] ePc, eInstr;
    logic [4:0]  eExc;
    logic        eBd, eValid;
    longint      eStall, eFlush;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: what decode should see after the last edge.
  logic [31:0] mPc, mInstr;
  logic [4:0]  mExc;
  logic        mBd, mValid;
  longint      mStall, mFlush;
  longint      cntMax;

  task automatic checkField(input string name, input longint act, input longint exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic q,
                               input logic er, input logic [31:0] epc,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic [4:0] exc, input logic bd);
    @(negedge clk);
    reset = r; en = e; req = q; eret_clr = er; eret_epc = epc;
    f_pc = pc; f_instr = ins; f_exc = exc; f_bd = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] ePc,
                             input logic [31:0] eInstr, input logic [4:0] eExc,
                             input logic eBd, input logic eValid,
                             input longint eStall, input longint eFlush);
    checkField({tag, ".d_pc"},    d_pc,    ePc);
    checkField({tag, ".d_instr"}, d_instr, eInstr);
    checkField({tag, ".d_exc"},   d_exc,   eExc);
    checkField({tag, ".d_bd"},    d_bd,    eBd);
    checkField({tag, ".d_valid"}, d_valid, eValid);
`ifdef FD_PERF_CNT_EN
    checkField({tag, ".stall_cnt"}, stall_cnt, eStall);
    checkField({tag, ".flush_cnt"}, flush_cnt, eFlush);
`else
    checkField({tag, ".stall_cnt"}, stall_cnt, 0);
    checkField({tag, ".flush_cnt"}, flush_cnt, 0);
    if (eStall < 0 || eFlush < 0) $display("[TB] note: negative count");
`endif
  endtask

  // Next decode contents follow directly from the documented rules.
  task automatic modelStep(input logic r, input logic e, input logic q,
                           input logic er, input logic [31:0] epc,
                           input logic [31:0] pc, input logic [31:0] ins,
                           input logic [4:0] exc, input logic bd);
    if (r) begin
      mPc = 32'h3000; mInstr = 0; mExc = 0; mBd = 0; mValid = 0;
      mStall = 0; mFlush = 0;
    end else if (q || er) begin
      mPc = q ? 32'h4180 : epc;
      mInstr = 0; mExc = 0; mBd = 0; mValid = 0;
      if (mFlush < cntMax) mFlush++;
    end else if (e) begin
      mPc = pc; mExc = exc; mBd = bd; mValid = 1;
      mInstr = (exc == 0) ? ins : 32'h0;
    end else begin
      if (mStall < cntMax) mStall++;
    end
  endtask

  task automatic modelDrive(input string tag, input logic r, input logic e,
                            input logic q, input logic er, input logic [31:0] epc,
                            input logic [31:0] pc, input logic [31:0] ins,
                            input logic [4:0] exc, input logic bd);
    modelStep(r, e, q, er, epc, pc, ins, exc, bd);
    applyStimulus(r, e, q, er, epc, pc, ins, exc, bd);
    checkOutput(tag, mPc, mInstr, mExc, mBd, mValid, mStall, mFlush);
  endtask

  initial begin
    cntMax = (64'd1 << CNT_W) - 1;
    reset = 1; en = 0; req = 0; eret_clr = 0; eret_epc = 0;
    f_pc = 0; f_instr = 0; f_exc = 0; f_bd = 0;

    //                 rst en req er  epc        fpc        finstr      fexc fbd  ePc        eInstr      eExc eBd eVal stall flush
    vecs.push_back('{1, 0, 0, 0, 32'h0,     32'h0,     32'h0,      0, 0, 32'h3000, 32'h0,      0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 32'h0,     32'h3000,  32'h3c011234,0, 0, 32'h3000, 32'h3c011234,0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,     32'h3004,  32'h24210001,0, 0, 32'h3000, 32'h3c011234,0, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,     32'h3004,  32'h24210001,0, 0, 32'h3000, 32'h3c011234,0, 0, 1, 2, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,     32'h3004,  32'h24210001,0, 0, 32'h3000, 32'h3c011234,0, 0, 1, 3, 0});
    vecs.push_back('{0, 0, 1, 0, 32'h0,     32'h3004,  32'h24210001,0, 1, 32'h4180, 32'h0,      0, 0, 0, 3, 1});
    vecs.push_back('{0, 1, 0, 1, 32'h3010,  32'h3008,  32'h8c220004,0, 1, 32'h3010, 32'h0,      0, 0, 0, 3, 2});
    vecs.push_back('{0, 1, 0, 0, 32'h0,     32'h3002,  32'hffffffff,4, 0, 32'h3002, 32'h0,      4, 0, 1, 3, 2});
    vecs.push_back('{0, 1, 0, 0, 32'h0,     32'h3008,  32'h8c220004,0, 1, 32'h3008, 32'h8c220004,0, 1, 1, 3, 2});
    vecs.push_back('{0, 0, 0, 0, 32'h0,     32'h300c,  32'h00000020,0, 0, 32'h3008, 32'h8c220004,0, 1, 1, 4, 2});
    vecs.push_back('{0, 1, 1, 1, 32'h3010,  32'h300c,  32'h00000020,0, 0, 32'h4180, 32'h0,      0, 0, 0, 4, 3});
    vecs.push_back('{0, 1, 0, 0, 32'h0,     32'h4180,  32'h40806000,0, 0, 32'h4180, 32'h40806000,0, 0, 1, 4, 3});
    vecs.push_back('{0, 0, 0, 0, 32'h0,     32'h4184,  32'h0,      0, 0, 32'h4180, 32'h40806000,0, 0, 1, 5, 3});
    vecs.push_back('{1, 0, 1, 0, 32'h0,     32'h4184,  32'h0,      0, 1, 32'h3000, 32'h0,      0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].eret, vecs[i].epc,
                    vecs[i].fpc, vecs[i].finstr, vecs[i].fexc, vecs[i].fbd);
      checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eInstr, vecs[i].eExc,
                  vecs[i].eBd, vecs[i].eValid, vecs[i].eStall, vecs[i].eFlush);
    end

    // Hand sequence: a bubble stays a bubble through a stall, then a
    // faulting fetch followed by reset in the middle of a stall.
    modelDrive("seq.rst",    1, 0, 0, 0, 0, 0, 0, 0, 0);
    modelDrive("seq.eret",   0, 1, 0, 1, 32'h3abc, 32'h3000, 32'h1234, 0, 1);
    modelDrive("seq.hold0",  0, 0, 0, 0, 0, 32'h3100, 32'h5555, 0, 1);
    modelDrive("seq.hold1",  0, 0, 0, 0, 0, 32'h3104, 32'h6666, 0, 0);
    modelDrive("seq.adel",   0, 1, 0, 0, 0, 32'h3abd, 32'hdeadbeef, 4, 1);
    modelDrive("seq.hold2",  0, 0, 0, 0, 0, 32'h3ac0, 32'h7777, 0, 0);
    modelDrive("seq.rstStl", 1, 0, 0, 0, 0, 32'h3ac0, 32'h7777, 0, 0);

    for (int n = 0; n < 400; n++) begin
      logic r, e, q, er, bd;
      logic [4:0] exc;
      r   = ($urandom_range(0, 39) == 0);
      q   = ($urandom_range(0, 9) == 0);
      er  = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 3) != 0);
      bd  = $urandom_range(0, 1);
      exc = ($urandom_range(0, 5) == 0) ? 5'd4 : 5'd0;
      modelDrive($sformatf("rnd%0d", n), r, e, q, er, $urandom, $urandom,
                 $urandom, exc, bd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
